// File: rtl/output_precision_packer.sv
// output_precision_packer
//   Packs 1, 2 or 4 consecutive activation vectors into one output word by
//   truncating each lane to ACT_W/K bits. K comes from the precision code
//   (0/3 -> 1, 1 -> 2, 2 -> 4). Two lane layouts are supported:
//     CNN : out lane m = {slot K-1 lane m, ..., slot 0 lane m}
//     FC  : out lane m = slot m/(N_DIM/K), source lanes K*j .. K*j+K-1,
//           j = m mod (N_DIM/K), lowest source lane in the LSBs
//   A flush emits a partially filled pack with the missing slots zeroed.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   enable        : global enable; low freezes all state, forces in_ready low
//   precision     : 2-bit precision code, latched at the first vector of a pack
//   mode_cnn      : 1 = CNN layout, 0 = FC/EWS layout, latched with precision
//   in_valid      : in_data valid
//   in_ready      : block accepts in_data this cycle
//   in_data       : N_DIM lanes of ACT_W bits, lane m at [ACT_W*m +: ACT_W]
//   flush         : single-cycle request to emit a partially filled pack
//   out_valid     : out_data holds a packed word
//   out_ready     : consumer accepts out_data
//   out_data      : packed word, lanes laid out as for in_data
//   out_partial   : word came from a flush and contains zero-filled slots
//   busy          : fill count > 0 or out_valid
module output_precision_packer #(
    parameter int unsigned N_DIM = 8,
    parameter int unsigned ACT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               precision,
    input  logic                     mode_cnn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DIM*ACT_W-1:0]   in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DIM*ACT_W-1:0]   out_data,
    output logic                     out_partial,
    output logic                     busy
);

    localparam int unsigned W   = N_DIM * ACT_W;
    localparam int unsigned SW2 = ACT_W / 2;   // slot width for K = 2
    localparam int unsigned SW4 = ACT_W / 4;   // slot width for K = 4
    localparam int unsigned LG2 = N_DIM / 2;   // out lanes per slot, FC, K = 2
    localparam int unsigned LG4 = N_DIM / 4;   // out lanes per slot, FC, K = 4

    // Index of the slot that completes a pack (K-1) for a precision code.
    function automatic logic [1:0] last_slot(input logic [1:0] prec);
        case (prec)
            2'd1:    last_slot = 2'd1;
            2'd2:    last_slot = 2'd3;
            default: last_slot = 2'd0;
        endcase
    endfunction

    // State
    logic [1:0]   fill_cnt;
    logic [1:0]   lat_prec;
    logic         lat_cnn;
    logic         pend_flush;
    logic [W-1:0] staging [4];

    // Control
    logic         in_xfer_c;
    logic         first_c;
    logic [1:0]   eff_prec_c;
    logic         eff_cnn_c;
    logic         out_free_c;
    logic         flush_req_c;
    logic         complete_c;
    logic         emit_partial_c;
    logic         emit_c;
    logic         pend_next_c;

    // Datapath
    logic [W-1:0] slot_c [4];
    logic [W-1:0] cnn2_c;
    logic [W-1:0] cnn4_c;
    logic [W-1:0] fc2_c;
    logic [W-1:0] fc4_c;
    logic [W-1:0] packed_c;

    // Handshake and status
    assign out_free_c = ~out_valid | out_ready;
    assign in_ready   = enable & ~reset & out_free_c;
    assign in_xfer_c  = in_valid & in_ready;
    assign busy       = (fill_cnt != 2'd0) | out_valid;

    // Mode of the pack in progress; a new pack takes the live inputs.
    assign first_c    = (fill_cnt == 2'd0);
    assign eff_prec_c = first_c ? precision : lat_prec;
    assign eff_cnn_c  = first_c ? mode_cnn  : lat_cnn;

    // A completing vector always wins over a flush; a flush with an
    // incoming non-completing vector emits that vector as part of the word.
    assign flush_req_c    = flush | pend_flush;
    assign complete_c     = in_xfer_c & (fill_cnt == last_slot(eff_prec_c));
    assign emit_partial_c = flush_req_c & ~complete_c &
                            (in_xfer_c | (~first_c & out_free_c));
    assign emit_c         = complete_c | emit_partial_c;
    assign pend_next_c    = flush_req_c & ~first_c & ~in_xfer_c & ~emit_c;

    // Slot view for emission: staged slots below fill count, the incoming
    // vector in the current slot, and zero everywhere else.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            slot_c[s] = '0;
            if (2'(s) < fill_cnt) begin
                slot_c[s] = staging[s];
            end else if ((2'(s) == fill_cnt) && in_xfer_c) begin
                slot_c[s] = in_data;
            end
        end
    end

    // Candidate packings for each K / layout combination.
    always_comb begin
        cnn2_c = '0;
        cnn4_c = '0;
        fc2_c  = '0;
        fc4_c  = '0;
        for (int m = 0; m < int'(N_DIM); m++) begin
            cnn2_c[m*ACT_W +: ACT_W] = {slot_c[1][m*ACT_W +: SW2],
                                        slot_c[0][m*ACT_W +: SW2]};
            cnn4_c[m*ACT_W +: ACT_W] = {slot_c[3][m*ACT_W +: SW4],
                                        slot_c[2][m*ACT_W +: SW4],
                                        slot_c[1][m*ACT_W +: SW4],
                                        slot_c[0][m*ACT_W +: SW4]};
            fc2_c[m*ACT_W +: ACT_W]  =
                {slot_c[2'(m / int'(LG2))][(2*(m % int'(LG2)) + 1)*ACT_W +: SW2],
                 slot_c[2'(m / int'(LG2))][(2*(m % int'(LG2)))*ACT_W     +: SW2]};
            fc4_c[m*ACT_W +: ACT_W]  =
                {slot_c[2'(m / int'(LG4))][(4*(m % int'(LG4)) + 3)*ACT_W +: SW4],
                 slot_c[2'(m / int'(LG4))][(4*(m % int'(LG4)) + 2)*ACT_W +: SW4],
                 slot_c[2'(m / int'(LG4))][(4*(m % int'(LG4)) + 1)*ACT_W +: SW4],
                 slot_c[2'(m / int'(LG4))][(4*(m % int'(LG4)))*ACT_W     +: SW4]};
        end
    end

    // Select the packing for the active precision and layout.
    always_comb begin
        packed_c = slot_c[0];
        case (eff_prec_c)
            2'd1:    packed_c = eff_cnn_c ? cnn2_c : fc2_c;
            2'd2:    packed_c = eff_cnn_c ? cnn4_c : fc4_c;
            default: packed_c = slot_c[0];
        endcase
    end

    // State update; reset overrides enable, enable low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt    <= 2'd0;
            lat_prec    <= 2'd0;
            lat_cnn     <= 1'b0;
            pend_flush  <= 1'b0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
            out_data    <= '0;
            for (int s = 0; s < 4; s++) begin
                staging[s] <= '0;
            end
        end else if (enable) begin
            if (in_xfer_c) begin
                if (first_c) begin
                    lat_prec <= precision;
                    lat_cnn  <= mode_cnn;
                end
                if (!emit_c) begin
                    staging[fill_cnt] <= in_data;
                    fill_cnt          <= fill_cnt + 2'd1;
                end
            end

            if (emit_c) begin
                out_data    <= packed_c;
                out_valid   <= 1'b1;
                out_partial <= emit_partial_c;
                fill_cnt    <= 2'd0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            pend_flush <= pend_next_c;
        end
    end

endmodule

// File: tb/tb_output_precision_packer.sv
// tb_output_precision_packer
//   Directed checks of output_precision_packer at N_DIM = 8, ACT_W = 8.
module tb_output_precision_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  precision;
    logic        mode_cnn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_partial;
    logic        busy;

    int tests = 0;
    int fails = 0;

    output_precision_packer #(.N_DIM(8), .ACT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .precision   (precision),
        .mode_cnn    (mode_cnn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_partial (out_partial),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        precision = 2'd0;
        mode_cnn  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ready_in_reset", 64'(in_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_partial", 64'(out_partial), 64'd0);

        // 4b CNN pack
        precision = 2'd1; mode_cnn = 1'b1; in_valid = 1'b1;
        in_data = rep(8'h0A);
        tick();
        chk("cnn4_busy_mid", 64'(busy), 64'd1);
        chk("cnn4_valid_mid", 64'(out_valid), 64'd0);
        in_data = rep(8'h0B);
        tick();
        in_valid = 1'b0;
        chk("cnn4_valid", 64'(out_valid), 64'd1);
        chk("cnn4_data", out_data, rep(8'hBA));
        chk("cnn4_partial", 64'(out_partial), 64'd0);
        tick();
        chk("cnn4_valid_drop", 64'(out_valid), 64'd0);
        chk("cnn4_idle", 64'(busy), 64'd0);

        // 2b FC pack, lane m = slot index
        precision = 2'd2; mode_cnn = 1'b0; in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_data = rep(8'(s));
            tick();
        end
        in_valid = 1'b0;
        chk("fc2_valid", 64'(out_valid), 64'd1);
        chk("fc2_data", out_data, 64'hFFFF_AAAA_5555_0000);
        tick();

        // 4b FC pack
        precision = 2'd1; mode_cnn = 1'b0; in_valid = 1'b1;
        in_data = 64'h0706_0504_0302_0100;
        tick();
        in_data = 64'h0F0E_0D0C_0B0A_0908;
        tick();
        in_valid = 1'b0;
        chk("fc4_data", out_data, 64'hFEDC_BA98_7654_3210);
        tick();

        // Backpressure
        precision = 2'd1; mode_cnn = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        in_data = rep(8'h01);
        tick();
        in_data = rep(8'h02);
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", out_data, rep(8'h21));
        in_data = rep(8'h03);
        #1;
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("bp_data_stable", out_data, rep(8'h21));
        chk("bp_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", 64'(in_ready), 64'd1);
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_busy_fill", 64'(busy), 64'd1);
        in_data = rep(8'h04);
        tick();
        in_valid = 1'b0;
        chk("bp_next_pack", out_data, rep(8'h43));
        tick();

        // Flush with nothing staged
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_noop", 64'(out_valid), 64'd0);

        // Partial flush, 2b CNN
        precision = 2'd2; mode_cnn = 1'b1; in_valid = 1'b1;
        in_data = rep(8'h03);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pflush_valid", 64'(out_valid), 64'd1);
        chk("pflush_data", out_data, rep(8'h03));
        chk("pflush_partial", 64'(out_partial), 64'd1);
        tick();
        chk("pflush_fill0", 64'(busy), 64'd0);

        // Flush coincident with a non-completing vector
        in_valid = 1'b1;
        in_data = rep(8'h01);
        tick();
        in_data = rep(8'h02); flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("cflush_data", out_data, rep(8'h09));
        chk("cflush_partial", 64'(out_partial), 64'd1);
        tick();

        // Reset mid-pack
        precision = 2'd1; mode_cnn = 1'b1; in_valid = 1'b1;
        in_data = rep(8'h05);
        tick();
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_data", out_data, 64'd0);
        in_valid = 1'b1;
        in_data = rep(8'h01);
        tick();
        in_data = rep(8'h02);
        tick();
        in_valid = 1'b0;
        chk("rstmid_pack", out_data, rep(8'h21));
        chk("rstmid_partial", 64'(out_partial), 64'd0);
        tick();

        // Precision change mid-pack
        precision = 2'd1; in_valid = 1'b1;
        in_data = rep(8'h07);
        tick();
        precision = 2'd0;
        in_data = rep(8'h08);
        tick();
        chk("pchg_pack4", out_data, rep(8'h87));
        in_data = rep(8'hC9);
        tick();
        in_valid = 1'b0;
        chk("pchg_pass8", out_data, rep(8'hC9));
        chk("pchg_valid", 64'(out_valid), 64'd1);
        tick();
        chk("pchg_drop", 64'(out_valid), 64'd0);

        // Enable low freezes state
        precision = 2'd1; in_valid = 1'b1;
        in_data = rep(8'h01);
        tick();
        enable = 1'b0;
        in_data = rep(8'h02);
        #1;
        chk("en_ready_low", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("en_frozen_valid", 64'(out_valid), 64'd0);
        chk("en_frozen_busy", 64'(busy), 64'd1);
        enable = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("en_resume", out_data, rep(8'h21));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
